// File: rtl/qam_bit_splitter_pkg.sv
// Shared constants and helpers for the QAM bit splitter and its demap-side counterparts.
package qam_split_pkg;

   localparam int MIN_BPS   = 2;
   localparam int MAX_BPS   = 8;
   localparam int MAX_HALF  = MAX_BPS / 2;
   localparam int BPS_QPSK  = 2;
   localparam int BPS_16QAM = 4;

   // Callers zero-extend narrower fields to MAX_HALF and truncate the result;
   // the Gray code of the low bits is unaffected by the extra zero MSBs.
   function automatic logic [MAX_HALF-1:0] bin2gray(input logic [MAX_HALF-1:0] b);
      return b ^ (b >> 1);
   endfunction

endpackage

// File: rtl/qam_bit_splitter_sym_reg.sv
// Symbol output register with valid/ready hold and a per-load toggle.
module qam_sym_reg #(
   parameter int HALF = 1
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            load,
   input  logic [HALF-1:0] i_in,
   input  logic [HALF-1:0] q_in,
   input  logic            sym_ready,
   output logic [HALF-1:0] sym_i,
   output logic [HALF-1:0] sym_q,
   output logic            sym_valid,
   output logic            sym_tgl
);

   logic [HALF-1:0] sym_i_q, sym_i_d;
   logic [HALF-1:0] sym_q_q, sym_q_d;
   logic            valid_q, valid_d;
   logic            tgl_q, tgl_d;

   // The producer only asserts load when the held symbol is free or being consumed.
   always_comb begin
      sym_i_d = sym_i_q;
      sym_q_d = sym_q_q;
      tgl_d   = tgl_q;
      valid_d = valid_q && !sym_ready;
      if (load) begin
         sym_i_d = i_in;
         sym_q_d = q_in;
         tgl_d   = !tgl_q;
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sym_i_q <= '0;
         sym_q_q <= '0;
         valid_q <= 1'b0;
         tgl_q   <= 1'b0;
      end else begin
         sym_i_q <= sym_i_d;
         sym_q_q <= sym_q_d;
         valid_q <= valid_d;
         tgl_q   <= tgl_d;
      end
   end

   assign sym_i     = sym_i_q;
   assign sym_q     = sym_q_q;
   assign sym_valid = valid_q;
   assign sym_tgl   = tgl_q;

endmodule

// File: rtl/qam_bit_splitter.sv
// Serial-to-symbol splitter: even-numbered bits feed I, odd feed Q, MSB first, optional Gray.
module qam_bit_splitter
   import qam_split_pkg::*;
#(
   parameter  int BPS   = 2,
   localparam int HALF  = BPS / 2,
   localparam int CNT_W = $clog2(BPS)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             flush,
   input  logic             gray_en,
   input  logic             bit_in,
   input  logic             bit_valid,
   output logic             bit_ready,
   output logic [HALF-1:0]  sym_i,
   output logic [HALF-1:0]  sym_q,
   output logic             sym_valid,
   input  logic             sym_ready,
   output logic             sym_tgl,
   output logic [CNT_W-1:0] bit_cnt
);

   if (BPS < MIN_BPS || BPS > MAX_BPS || (BPS % 2) != 0) begin : g_bad_bps
      $error("qam_bit_splitter: BPS must be even and within 2..8");
   end

   localparam logic [CNT_W-1:0] LAST = CNT_W'(BPS - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [HALF-1:0]  i_sr_q, i_sr_d;
   logic [HALF-1:0]  q_sr_q, q_sr_d;
   logic [HALF:0]    i_cat, q_cat;
   logic [HALF-1:0]  full_i, full_q;
   logic [HALF-1:0]  load_i, load_q;
   logic             last_bit, accept, complete;

   // Stall only when the closing bit would overwrite a symbol nobody has taken.
   always_comb begin
      last_bit  = (cnt_q == LAST);
      bit_ready = reset_n && !flush && !(last_bit && sym_valid && !sym_ready);
      accept    = bit_valid && bit_ready;
      complete  = accept && last_bit;
   end

   // The closing bit is always odd-numbered, so it lands in Q on the fly.
   always_comb begin
      i_cat  = {i_sr_q, bit_in};
      q_cat  = {q_sr_q, bit_in};
      full_i = i_sr_q;
      full_q = q_cat[HALF-1:0];
      load_i = gray_en ? HALF'(bin2gray(MAX_HALF'(full_i))) : full_i;
      load_q = gray_en ? HALF'(bin2gray(MAX_HALF'(full_q))) : full_q;
   end

   always_comb begin
      cnt_d  = cnt_q;
      i_sr_d = i_sr_q;
      q_sr_d = q_sr_q;
      if (flush) begin
         cnt_d  = '0;
         i_sr_d = '0;
         q_sr_d = '0;
      end else if (complete) begin
         cnt_d  = '0;
         i_sr_d = '0;
         q_sr_d = '0;
      end else if (accept) begin
         cnt_d = cnt_q + CNT_W'(1);
         if (!cnt_q[0]) i_sr_d = i_cat[HALF-1:0];
         else           q_sr_d = q_cat[HALF-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt_q  <= '0;
         i_sr_q <= '0;
         q_sr_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         i_sr_q <= i_sr_d;
         q_sr_q <= q_sr_d;
      end
   end

   assign bit_cnt = cnt_q;

   qam_sym_reg #(.HALF(HALF)) u_sym_reg (
      .clk       (clk),
      .reset_n   (reset_n),
      .load      (complete),
      .i_in      (load_i),
      .q_in      (load_q),
      .sym_ready (sym_ready),
      .sym_i     (sym_i),
      .sym_q     (sym_q),
      .sym_valid (sym_valid),
      .sym_tgl   (sym_tgl)
   );

endmodule

// File: tb/tb_qam_bit_splitter.sv
// Directed and randomised checks of the splitter at BPS = 2, 4, 6 and 8.
module tb_qam_bit_splitter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   logic       rst2, fl2, gr2, bi2, bv2, sr2, br2, sv2, st2;
   logic [0:0] si2, sq2, bc2;
   logic       rst4, fl4, gr4, bi4, bv4, sr4, br4, sv4, st4;
   logic [1:0] si4, sq4, bc4;
   logic       rst6, fl6, gr6, bi6, bv6, sr6, br6, sv6, st6;
   logic [2:0] si6, sq6, bc6;
   logic       rst8, fl8, gr8, bi8, bv8, sr8, br8, sv8, st8;
   logic [3:0] si8, sq8;
   logic [2:0] bc8;

   qam_bit_splitter #(.BPS(2)) u_d2 (
      .clk(clk), .reset_n(rst2), .flush(fl2), .gray_en(gr2), .bit_in(bi2), .bit_valid(bv2),
      .bit_ready(br2), .sym_i(si2), .sym_q(sq2), .sym_valid(sv2), .sym_ready(sr2),
      .sym_tgl(st2), .bit_cnt(bc2));
   qam_bit_splitter #(.BPS(4)) u_d4 (
      .clk(clk), .reset_n(rst4), .flush(fl4), .gray_en(gr4), .bit_in(bi4), .bit_valid(bv4),
      .bit_ready(br4), .sym_i(si4), .sym_q(sq4), .sym_valid(sv4), .sym_ready(sr4),
      .sym_tgl(st4), .bit_cnt(bc4));
   qam_bit_splitter #(.BPS(6)) u_d6 (
      .clk(clk), .reset_n(rst6), .flush(fl6), .gray_en(gr6), .bit_in(bi6), .bit_valid(bv6),
      .bit_ready(br6), .sym_i(si6), .sym_q(sq6), .sym_valid(sv6), .sym_ready(sr6),
      .sym_tgl(st6), .bit_cnt(bc6));
   qam_bit_splitter #(.BPS(8)) u_d8 (
      .clk(clk), .reset_n(rst8), .flush(fl8), .gray_en(gr8), .bit_in(bi8), .bit_valid(bv8),
      .bit_ready(br8), .sym_i(si8), .sym_q(sq8), .sym_valid(sv8), .sym_ready(sr8),
      .sym_tgl(st8), .bit_cnt(bc8));

   task automatic test_reset();
      {rst2, rst4, rst6, rst8} = '0;
      {fl2, gr2, bi2, bv2, sr2} = '0;
      {fl4, gr4, bi4, bv4, sr4} = '0;
      {fl6, gr6, bi6, bv6, sr6} = '0;
      {fl8, gr8, bi8, bv8, sr8} = '0;
      repeat (3) @(negedge clk);
      #1;
      n_chk++;
      if ({br2, br4, br6, br8} !== 4'b0000) begin
         n_fail++; $display("FAIL reset_ready: got %b want 0000", {br2, br4, br6, br8});
      end
      n_chk++;
      if ({sv2, st2, bc2, si2, sq2} !== 5'b0 || {sv8, st8, bc8, si8, sq8} !== 13'b0) begin
         n_fail++; $display("FAIL reset_outputs: got d2=%b d8=%b want all zero",
                            {sv2, st2, bc2, si2, sq2}, {sv8, st8, bc8, si8, sq8});
      end
      {rst2, rst4, rst6, rst8} = 4'b1111;
      #1;
      n_chk++;
      if ({br2, br4, br6, br8} !== 4'b1111) begin
         n_fail++; $display("FAIL release_ready: got %b want 1111", {br2, br4, br6, br8});
      end
   endtask

   task automatic test_qpsk();
      sr2 = 1'b1;
      @(negedge clk); bv2 = 1'b1; bi2 = 1'b1;
      @(negedge clk); bi2 = 1'b0;
      @(negedge clk); bi2 = 1'b1;
      #1;
      n_chk++;
      if ({sv2, si2, sq2, st2} !== 4'b1101) begin
         n_fail++; $display("FAIL qpsk_sym0: got v,i,q,t=%b want 1101", {sv2, si2, sq2, st2});
      end
      @(negedge clk); bi2 = 1'b1;
      #1;
      n_chk++;
      if ({sv2, st2} !== 2'b01) begin
         n_fail++; $display("FAIL qpsk_gap: got v,t=%b want 01", {sv2, st2});
      end
      @(negedge clk); bv2 = 1'b0;
      #1;
      n_chk++;
      if ({sv2, si2, sq2, st2} !== 4'b1110) begin
         n_fail++; $display("FAIL qpsk_sym1: got v,i,q,t=%b want 1110", {sv2, si2, sq2, st2});
      end
   endtask

   task automatic test_gray16();
      logic bs[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      sr4 = 1'b1; gr4 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); bv4 = 1'b1; bi4 = bs[i];
      end
      @(negedge clk); bv4 = 1'b0; gr4 = 1'b0;
      #1;
      n_chk++;
      if ({sv4, si4, sq4, bc4} !== 7'b1_10_11_00) begin
         n_fail++; $display("FAIL gray16: got v,i,q,cnt=%b want 1101100", {sv4, si4, sq4, bc4});
      end
   endtask

   task automatic test_stall();
      logic bs[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      int n = 0;
      int cyc = 0;
      @(negedge clk); sr4 = 1'b0;
      while (n < 7 && cyc < 50) begin
         @(negedge clk); bv4 = 1'b1; bi4 = bs[n];
         #1;
         if (br4) n++;
         cyc++;
      end
      n_chk++;
      if (n != 7) begin
         n_fail++; $display("FAIL stall_feed: got %0d bits accepted want 7", n);
      end
      for (int r = 0; r < 3; r++) begin
         @(negedge clk); bi4 = bs[7];
         #1;
         n_chk++;
         if ({br4, bc4, sv4, si4, sq4} !== 8'b0_11_1_10_01) begin
            n_fail++; $display("FAIL stall_hold: got rdy,cnt,v,i,q=%b want 01111001",
                               {br4, bc4, sv4, si4, sq4});
         end
      end
      @(negedge clk); sr4 = 1'b1;
      #1;
      n_chk++;
      if (br4 !== 1'b1) begin
         n_fail++; $display("FAIL stall_release_ready: got %b want 1", br4);
      end
      @(negedge clk); sr4 = 1'b0; bv4 = 1'b0;
      #1;
      n_chk++;
      if ({sv4, si4, sq4, bc4} !== 7'b1_01_11_00) begin
         n_fail++; $display("FAIL stall_sym1: got v,i,q,cnt=%b want 1011100", {sv4, si4, sq4, bc4});
      end
   endtask

   task automatic test_flush();
      logic bs[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
      @(negedge clk); bv4 = 1'b1; bi4 = 1'b1;
      @(negedge clk); bi4 = 1'b1;
      @(negedge clk); fl4 = 1'b1; bi4 = 1'b0;
      #1;
      n_chk++;
      if ({br4, bc4} !== 3'b0_10) begin
         n_fail++; $display("FAIL flush_ready: got rdy,cnt=%b want 010", {br4, bc4});
      end
      @(negedge clk); fl4 = 1'b0; bv4 = 1'b0;
      #1;
      n_chk++;
      if ({bc4, sv4, si4, sq4} !== 7'b00_1_01_11) begin
         n_fail++; $display("FAIL flush_state: got cnt,v,i,q=%b want 0010111", {bc4, sv4, si4, sq4});
      end
      sr4 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); bv4 = 1'b1; bi4 = bs[i];
      end
      @(negedge clk); bv4 = 1'b0;
      #1;
      n_chk++;
      if ({sv4, si4, sq4, bc4} !== 7'b1_10_00_00) begin
         n_fail++; $display("FAIL flush_next_sym: got v,i,q,cnt=%b want 1100000", {sv4, si4, sq4, bc4});
      end
   endtask

   task automatic test_reset_mid();
      logic bs[9] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      logic bn[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      sr6 = 1'b0;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk); bv6 = 1'b1; bi6 = bs[i];
      end
      @(negedge clk); rst6 = 1'b0; bv6 = 1'b0;
      #1;
      n_chk++;
      if ({br6, sv6, si6, sq6, bc6} !== 11'b0_1_110_011_011) begin
         n_fail++; $display("FAIL reset_mid_before: got rdy,v,i,q,cnt=%b want 01110011011",
                            {br6, sv6, si6, sq6, bc6});
      end
      @(negedge clk);
      #1;
      n_chk++;
      if ({br6, sv6, si6, sq6, bc6, st6} !== 12'b0) begin
         n_fail++; $display("FAIL reset_mid_after: got rdy,v,i,q,cnt,t=%b want all zero",
                            {br6, sv6, si6, sq6, bc6, st6});
      end
      rst6 = 1'b1; sr6 = 1'b1;
      for (int i = 0; i < 6; i++) begin
         bv6 = 1'b1; bi6 = bn[i];
         @(negedge clk);
      end
      bv6 = 1'b0;
      #1;
      n_chk++;
      if ({sv6, si6, sq6, st6} !== 8'b1_011_101_1) begin
         n_fail++; $display("FAIL reset_mid_fresh: got v,i,q,t=%b want 10111011", {sv6, si6, sq6, st6});
      end
   endtask

   task automatic test_random();
      logic [3:0] mi = '0;
      logic [3:0] mq = '0;
      logic [3:0] qi[$];
      logic [3:0] qq[$];
      int   k = 0, acc = 0, cons = 0, tg = 0, cyc = 0;
      logic ptg;
      gr8 = 1'b1;
      ptg = st8;
      while ((acc < 800 || qi.size() > 0 || sv8) && cyc < 20000) begin
         @(negedge clk);
         bv8 = (acc < 800) && ($urandom_range(0, 3) != 0);
         bi8 = 1'($urandom_range(0, 1));
         sr8 = (acc >= 800) || ($urandom_range(0, 2) != 0);
         #1;
         if (st8 !== ptg) tg++;
         ptg = st8;
         if (sv8 && sr8) begin
            n_chk++;
            if (qi.size() == 0) begin
               n_fail++; $display("FAIL rand_extra_symbol: got i=%h q=%h want none", si8, sq8);
            end else begin
               if ({si8, sq8} !== {qi[0], qq[0]}) begin
                  n_fail++; $display("FAIL rand_symbol %0d: got i=%h q=%h want i=%h q=%h",
                                     cons, si8, sq8, qi[0], qq[0]);
               end
               void'(qi.pop_front());
               void'(qq.pop_front());
            end
            cons++;
         end
         if (bv8 && br8) begin
            if (k % 2 == 0) mi[3 - k / 2] = bi8;
            else            mq[3 - k / 2] = bi8;
            k++;
            acc++;
            if (k == 8) begin
               qi.push_back(mi ^ (mi >> 1));
               qq.push_back(mq ^ (mq >> 1));
               k = 0;
            end
         end
         cyc++;
      end
      bv8 = 1'b0;
      n_chk++;
      if (acc != 800 || cons != 100) begin
         n_fail++; $display("FAIL rand_counts: got bits=%0d symbols=%0d want 800 and 100", acc, cons);
      end
      n_chk++;
      if (tg != 100) begin
         n_fail++; $display("FAIL rand_toggles: got %0d want 100", tg);
      end
   endtask

   initial begin
      test_reset();
      test_qpsk();
      test_gray16();
      test_stall();
      test_flush();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
